mux_nx1_pipe: RTL and testbench
===============================

Name: mux_nx1_pipe

Overview:
- Parametrised N-to-1 selector with a registered output stage and valid/ready handshakes on both sides.
- Generalises the combinational 2:1 mux used in the datapath to any input count.
- Adds a two-entry (main + skid) buffer so upstream and downstream can stall independently, plus detection and counting of out-of-range selects.
- Sits between multi-source producers (e.g. writeback / forwarding sources) and a single registered consumer.

Parameters:
- DATA_WIDTH, 12, width of each input channel and of o_data.
- NUM_INPUTS, 4, number of input channels (≥2).
- SEL_WIDTH, $clog2(NUM_INPUTS), width of i_sel (≥1).
- ERR_CNT_WIDTH, 8, width of the saturating out-of-range-select counter.

Ports:
- i_clk, input, 1, clock; all state updates on the rising edge.
- i_rst, input, 1, asynchronous active-high reset.
- i_data, input, NUM_INPUTS*DATA_WIDTH, packed channels; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_sel, input, SEL_WIDTH, channel select; sampled only on accept.
- i_valid, input, 1, upstream data/select valid.
- o_ready, output, 1, block can accept this cycle.
- i_flush, input, 1, synchronous clear of buffered entries.
- o_data, output, DATA_WIDTH, selected data held in the main entry.
- o_valid, output, 1, o_data/o_sel_err valid.
- i_ready, input, 1, downstream accepts.
- o_sel_err, output, 1, current output entry came from an out-of-range select.
- o_err_cnt, output, ERR_CNT_WIDTH, saturating count of accepted out-of-range selects.

Behaviour:
- Handshake definitions:
  - accept = i_valid & o_ready.
  - drain = o_valid & i_ready.
  - Producer must hold i_data/i_sel stable while i_valid=1 and o_ready=0. The block does not check this.
- Mux function, evaluated at accept:
  - sel < NUM_INPUTS: entry data = channel sel, err = 0.
  - sel ≥ NUM_INPUTS: entry data = 0, err = 1. This is only reachable when NUM_INPUTS is not a power of 2.
- Entries: main (data, err) and skid (data, err). Outputs are driven only from main, so there is no combinational path from i_data/i_sel to o_data. Latency from accept to o_valid is 1 cycle.
- State machine (Moore for o_ready and o_valid):
  - EMPTY: o_valid=0, o_ready=1.
  - ONE: o_valid=1, o_ready=1.
  - FULL: o_valid=1, o_ready=0.
- Transitions:
  - EMPTY + accept → ONE, main←mux.
  - ONE + accept & !drain → FULL, skid←mux.
  - ONE + drain & !accept → EMPTY.
  - ONE + accept & drain → ONE, main←mux.
  - ONE + neither → ONE, hold.
  - FULL + drain → ONE, main←skid.
  - FULL + !drain → FULL, hold.
- Ordering: strict FIFO; no entry is ever dropped or duplicated except by flush or reset. Sustained throughput is 1 per cycle when i_ready=1.
- i_flush:
  - Next state is EMPTY regardless of accept or drain.
  - An accept in the flush cycle is discarded and does not increment o_err_cnt.
  - A drain in the flush cycle still completes downstream.
  - o_err_cnt is not cleared.
- o_err_cnt:
  - +1 on each accept with sel ≥ NUM_INPUTS and no flush.
  - Saturates at all-ones and never wraps.
- Reset (asynchronous, any time, including mid-transfer):
  - state=EMPTY, o_valid=0, o_ready=1, o_data=0, o_sel_err=0, o_err_cnt=0.
  - Skid contents are cleared to 0.
- Idle outputs: o_data and o_sel_err hold their last value when o_valid=0. The consumer must ignore them.

Test Plan:
- Basic select: defaults; i_data channels = 0x111, 0x222, 0x333, 0x444; accept sel=2 with i_ready=1 → next cycle o_valid=1, o_data=0x333, o_sel_err=0.
- Backpressure: i_ready=0; accept sel=0 then sel=3 on consecutive cycles → o_ready=0 after the second accept, o_data=0x111. Raise i_ready → outputs 0x111 then 0x444 on consecutive cycles, o_ready returns to 1.
- Streaming: i_ready=1, i_valid=1, sel cycles 0,1,2,3 for 8 cycles → o_data follows the same order one cycle late, o_ready stays 1, no gaps.
- Out-of-range select: NUM_INPUTS=3, SEL_WIDTH=2; accept sel=3 → o_data=0, o_sel_err=1, o_err_cnt=1. With ERR_CNT_WIDTH=2, 5 such accepts → o_err_cnt=3.
- Flush: reach FULL, then assert i_flush together with i_valid → next cycle o_valid=0, o_ready=1, o_err_cnt unchanged.
- Async reset mid-operation: in FULL, assert i_rst between clock edges → o_valid=0, o_ready=1, o_data=0, o_err_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// N-to-1 selector feeding a two-entry (main + skid) registered buffer with
// valid/ready on both sides and a saturating out-of-range select counter.

module mux_nx1_pipe_lane #(
  parameter int DATA_WIDTH = 12,
  parameter int SEL_WIDTH  = 2,
  parameter int IDX        = 0
) (
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  assign dout = (sel == SEL_WIDTH'(IDX)) ? din : '0;
endmodule

module mux_nx1_pipe #(
  parameter int DATA_WIDTH    = 12,
  parameter int NUM_INPUTS    = 4,
  parameter int SEL_WIDTH     = $clog2(NUM_INPUTS),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic                             i_flush,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_sel_err,
  output logic [ERR_CNT_WIDTH-1:0]         o_err_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ch;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lane_out;
  logic [DATA_WIDTH-1:0]                 mux_data;
  logic                                  sel_oor;
  entry_t                                mux_ent, main_q, skid_q;
  state_t                                state_q, state_d;
  logic                                  accept, drain;
  logic                                  ld_main_mux, ld_main_skid, ld_skid;

  assign ch = i_data;

  // Each lane passes its channel only when selected; an out-of-range select
  // matches no lane, so the OR-reduction naturally yields zero.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
    mux_nx1_pipe_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .SEL_WIDTH (SEL_WIDTH),
      .IDX       (k)
    ) u_lane (
      .sel (i_sel),
      .din (ch[k]),
      .dout(lane_out[k])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) mux_data |= lane_out[k];
  end

  assign sel_oor      = ({1'b0, i_sel} >= (SEL_WIDTH+1)'(NUM_INPUTS));
  assign mux_ent.data = mux_data;
  assign mux_ent.err  = sel_oor;

  assign o_valid = (state_q != S_EMPTY);
  assign o_ready = (state_q != S_FULL);
  assign accept  = i_valid & o_ready;
  assign drain   = o_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ld_main_mux  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      S_EMPTY: if (accept) begin
        state_d     = S_ONE;
        ld_main_mux = 1'b1;
      end
      S_ONE: begin
        if (accept && !drain) begin
          state_d = S_FULL;
          ld_skid = 1'b1;
        end else if (drain && !accept) begin
          state_d = S_EMPTY;
        end else if (accept && drain) begin
          ld_main_mux = 1'b1;
        end
      end
      S_FULL: if (drain) begin
        state_d      = S_ONE;
        ld_main_skid = 1'b1;
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush discards any accept; a concurrent drain has already completed.
    if (i_flush) begin
      state_d      = S_EMPTY;
      ld_main_mux  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_mux)       main_q <= mux_ent;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= mux_ent;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_err_cnt <= '0;
    else if (accept && sel_oor && !i_flush && (o_err_cnt != '1))
      o_err_cnt <= o_err_cnt + 1'b1;
  end

  assign o_data    = main_q.data;
  assign o_sel_err = main_q.err;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed + random bench for mux_nx1_pipe: a 4-input default instance and a
// 3-input instance with a 2-bit error counter, both against a queue model.

module tb_mux_nx1_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] data;
  logic [1:0]  sel;
  logic        vld, flush, rdy_dn;

  logic        rdy4, vld4, err4;
  logic [11:0] d4;
  logic [7:0]  cnt4;
  logic        rdy3, vld3, err3;
  logic [11:0] d3;
  logic [1:0]  cnt3;

  always #5 clk = ~clk;

  mux_nx1_pipe u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_sel(sel), .i_valid(vld),
    .o_ready(rdy4), .i_flush(flush), .o_data(d4), .o_valid(vld4),
    .i_ready(rdy_dn), .o_sel_err(err4), .o_err_cnt(cnt4)
  );

  mux_nx1_pipe #(.DATA_WIDTH(12), .NUM_INPUTS(3), .SEL_WIDTH(2), .ERR_CNT_WIDTH(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data[35:0]), .i_sel(sel), .i_valid(vld),
    .o_ready(rdy3), .i_flush(flush), .o_data(d3), .o_valid(vld3),
    .i_ready(rdy_dn), .o_sel_err(err3), .o_err_cnt(cnt3)
  );

  typedef struct {
    logic [11:0] d;
    logic        e;
  } ent_t;

  ent_t q [2][$];
  int   cnt [2];
  int   nin [2]  = '{4, 3};
  int   cmax [2] = '{255, 3};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_mux(input int n, input logic [1:0] s, input logic [47:0] d);
    ent_t r;
    if (int'(s) < n) begin
      r.d = d[int'(s)*12 +: 12];
      r.e = 1'b0;
    end else begin
      r.d = '0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  task automatic compare_all();
    chk("dut4.valid", 32'(vld4), 32'(q[0].size() > 0));
    chk("dut4.ready", 32'(rdy4), 32'(q[0].size() < 2));
    chk("dut4.cnt",   32'(cnt4), cnt[0]);
    if (q[0].size() > 0) begin
      chk("dut4.data", 32'(d4),   32'(q[0][0].d));
      chk("dut4.err",  32'(err4), 32'(q[0][0].e));
    end
    chk("dut3.valid", 32'(vld3), 32'(q[1].size() > 0));
    chk("dut3.ready", 32'(rdy3), 32'(q[1].size() < 2));
    chk("dut3.cnt",   32'(cnt3), cnt[1]);
    if (q[1].size() > 0) begin
      chk("dut3.data", 32'(d3),   32'(q[1][0].d));
      chk("dut3.err",  32'(err3), 32'(q[1][0].e));
    end
  endtask

  // Compare current outputs, advance the model with the applied inputs, clock.
  task automatic step();
    compare_all();
    for (int m = 0; m < 2; m++) begin
      bit acc, drn;
      acc = vld && (q[m].size() < 2);
      drn = rdy_dn && (q[m].size() > 0);
      if (flush) q[m].delete();
      else begin
        if (drn) void'(q[m].pop_front());
        if (acc) begin
          q[m].push_back(ref_mux(nin[m], sel, data));
          if (int'(sel) >= nin[m] && cnt[m] < cmax[m]) cnt[m]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      cnt[m] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data = '0; sel = '0; vld = 1'b0; flush = 1'b0; rdy_dn = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst.valid", 32'(vld4), 32'd0);
    chk("rst.ready", 32'(rdy4), 32'd1);
    chk("rst.data",  32'(d4),   32'd0);
    chk("rst.err",   32'(err4), 32'd0);
    chk("rst.cnt",   32'(cnt4), 32'd0);
    rst = 1'b0;

    // Basic select
    data = {12'h444, 12'h333, 12'h222, 12'h111};
    rdy_dn = 1'b1; vld = 1'b1; sel = 2'd2;
    step();
    vld = 1'b0;
    chk("basic.valid", 32'(vld4), 32'd1);
    chk("basic.data",  32'(d4),   32'h333);
    chk("basic.err",   32'(err4), 32'd0);
    step();

    // Backpressure
    do_reset();
    rdy_dn = 1'b0; vld = 1'b1; sel = 2'd0;
    step();
    sel = 2'd3;
    step();
    vld = 1'b0;
    chk("bp.ready", 32'(rdy4), 32'd0);
    chk("bp.data0", 32'(d4),   32'h111);
    rdy_dn = 1'b1;
    step();
    chk("bp.data1", 32'(d4),   32'h444);
    chk("bp.ready1", 32'(rdy4), 32'd1);
    step();

    // Streaming
    do_reset();
    rdy_dn = 1'b1; vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      step();
      chk("stream.data",  32'(d4),   32'h111 * (i % 4 + 1));
      chk("stream.ready", 32'(rdy4), 32'd1);
    end
    vld = 1'b0;
    step();

    // Out-of-range select on the 3-input instance
    do_reset();
    rdy_dn = 1'b1; vld = 1'b1; sel = 2'd3;
    step();
    vld = 1'b0;
    chk("oor.data", 32'(d3),   32'd0);
    chk("oor.err",  32'(err3), 32'd1);
    chk("oor.cnt",  32'(cnt3), 32'd1);
    vld = 1'b1;
    for (int i = 0; i < 4; i++) step();
    vld = 1'b0;
    step();
    chk("oor.sat",  32'(cnt3), 32'd3);
    chk("oor.cnt4", 32'(cnt4), 32'd0);

    // Flush from FULL with a concurrent accept
    do_reset();
    rdy_dn = 1'b0; vld = 1'b1; sel = 2'd3;
    step();
    step();
    chk("flush.full", 32'(rdy4), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; vld = 1'b0;
    chk("flush.valid", 32'(vld4), 32'd0);
    chk("flush.ready", 32'(rdy4), 32'd1);
    chk("flush.cnt3",  32'(cnt3), 32'd2);

    // Asynchronous reset between edges while FULL
    vld = 1'b1; sel = 2'd3;
    step();
    step();
    vld = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(vld4), 32'd0);
    chk("arst.ready", 32'(rdy4), 32'd1);
    chk("arst.data",  32'(d4),   32'd0);
    chk("arst.cnt3",  32'(cnt3), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      vld    = 1'($urandom_range(0, 3) != 0);
      rdy_dn = 1'($urandom_range(0, 2) != 0);
      flush  = 1'($urandom_range(0, 15) == 0);
      sel    = 2'($urandom_range(0, 3));
      data   = {16'($urandom), 32'($urandom)};
      step();
    end
    flush = 1'b0; vld = 1'b0;
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
